// File: rtl/red_pkg.sv
// Shared types and limits for red_expand: FSM encoding, nibble/sum ranges, input legality check.
package red_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPLIT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NIB_MIN     = -8;
    localparam int NIB_MAX     = 7;
    localparam int SUM_MIN     = -64;
    localparam int SUM_MAX     = 56;
    localparam int NUM_NIBBLES = 8;

    // Legal target: clean 7-bit sign extension and within what eight nibbles can reach.
    function automatic logic sum_legal(input logic [15:0] s);
        logic sext_ok;
        int   v;
        sext_ok = (&s[15:6]) | ~(|s[15:6]);
        v       = int'($signed(s));
        return sext_ok && (v >= SUM_MIN) && (v <= SUM_MAX);
    endfunction

endpackage

// File: rtl/nibble_clamp.sv
// Greedy step of the RED split: clamp the remaining sum to one signed nibble.
module nibble_clamp
    import red_pkg::*;
(
    input  logic signed [6:0] remaining,
    output logic        [3:0] nib,
    output logic signed [6:0] rem_next
);

    localparam logic signed [6:0] HI = 7'(NIB_MAX);
    localparam logic signed [6:0] LO = 7'(NIB_MIN);

    logic signed [6:0] n7;

    always_comb begin
        if (remaining > HI)
            n7 = HI;
        else if (remaining < LO)
            n7 = LO;
        else
            n7 = remaining;
        nib      = n7[3:0];
        rem_next = remaining - n7;
    end

endmodule

// File: rtl/red_expand.sv
// Inverse of the ALU RED reduction: emits one signed nibble per cycle into (A, B).
// Optional early exit on a zero remainder: define RED_EXPAND_EARLY_EXIT_EN.
module red_expand
    import red_pkg::*;
#(
    parameter int INTERLEAVE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_sum,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_a,
    output logic [15:0] out_b,
    output logic        out_err
);

    state_t            state;
    logic signed [6:0] remaining;
    logic        [2:0] idx;
    logic        [3:0] nib;
    logic signed [6:0] rem_next;
    logic              sel_b;
    logic        [1:0] pos;
    logic              early;
    logic              last;

    nibble_clamp u_clamp (
        .remaining (remaining),
        .nib       (nib),
        .rem_next  (rem_next)
    );

    // Slot decode: which operand and which nibble position idx lands in.
    always_comb begin
        if (INTERLEAVE != 0) begin
            sel_b = idx[0];
            pos   = idx[2:1];
        end else begin
            sel_b = idx[2];
            pos   = idx[1:0];
        end
    end

`ifdef RED_EXPAND_EARLY_EXIT_EN
    // Unwritten slots are already zero, so stop as soon as nothing is left.
    assign early = (remaining == '0);
    assign last  = (idx == 3'd7) || (rem_next == '0);
`else
    assign early = 1'b0;
    assign last  = (idx == 3'd7);
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_a     <= '0;
            out_b     <= '0;
            out_err   <= 1'b0;
            remaining <= '0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        out_a <= '0;
                        out_b <= '0;
                        idx   <= '0;
                        if (sum_legal(in_sum)) begin
                            remaining <= in_sum[6:0];
                            out_err   <= 1'b0;
                            state     <= SPLIT;
                        end else begin
                            out_err <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                SPLIT: begin
                    if (early) begin
                        state <= DONE;
                    end else begin
                        if (sel_b)
                            out_b[{pos, 2'b00} +: 4] <= nib;
                        else
                            out_a[{pos, 2'b00} +: 4] <= nib;
                        remaining <= rem_next;
                        idx       <= idx + 3'd1;
                        if (last)
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_red_expand.sv
// Directed bench for red_expand: sequential and interleaved fill orders driven side by side.
module tb_red_expand;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_sum;
    logic        out_ready;
    logic        in_ready0, out_valid0, out_err0;
    logic [15:0] out_a0, out_b0;
    logic        in_ready1, out_valid1, out_err1;
    logic [15:0] out_a1, out_b1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    red_expand #(.INTERLEAVE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_sum(in_sum), .out_valid(out_valid0), .out_ready(out_ready),
        .out_a(out_a0), .out_b(out_b0), .out_err(out_err0)
    );

    red_expand #(.INTERLEAVE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_sum(in_sum), .out_valid(out_valid1), .out_ready(out_ready),
        .out_a(out_a1), .out_b(out_b1), .out_err(out_err1)
    );

    function automatic int red_of(input logic [15:0] a, input logic [15:0] b);
        int s;
        logic [3:0] na, nb;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            na = a[i*4 +: 4];
            nb = b[i*4 +: 4];
            s += int'($signed(na)) + int'($signed(nb));
        end
        return s;
    endfunction

    task automatic send(input logic [15:0] s);
        @(negedge clk);
        in_valid = 1'b1;
        in_sum   = s;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sum   = 16'hDEAD;
    endtask

    // Cycle index (handshake = 0) at which dut0 raises out_valid; -1 on timeout.
    task automatic wait_out(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (out_valid0) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic accept_out;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        n_cmp++; if (in_ready0 !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready0); end
        n_cmp++; if (out_valid0 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid0); end
        n_cmp++; if ({out_a0, out_b0, out_err0} !== 33'd0) begin n_bad++; $display("FAIL reset_outputs got=%h/%h/%b want=0", out_a0, out_b0, out_err0); end
        n_cmp++; if ({in_ready1, out_valid1} !== 2'b10) begin n_bad++; $display("FAIL reset_dut1 got=%b%b want=10", in_ready1, out_valid1); end
    endtask

    task automatic test_basic;
        int lat;
        send(16'h0014);
        wait_out(lat);
        n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL lat20 got=%0d want=9", lat); end
        n_cmp++; if ({out_a0, out_b0, out_err0} !== {16'h0677, 16'h0000, 1'b0}) begin n_bad++; $display("FAIL seq20 got=%h/%h/%b want=0677/0000/0", out_a0, out_b0, out_err0); end
        n_cmp++; if ({out_a1, out_b1, out_err1} !== {16'h0067, 16'h0007, 1'b0}) begin n_bad++; $display("FAIL ilv20 got=%h/%h/%b want=0067/0007/0", out_a1, out_b1, out_err1); end
        accept_out();
    endtask

    task automatic test_extremes;
        int lat;
        send(16'hFFC0);
        wait_out(lat);
        n_cmp++; if ({out_a0, out_b0, out_err0} !== {16'h8888, 16'h8888, 1'b0}) begin n_bad++; $display("FAIL min64 got=%h/%h/%b want=8888/8888/0", out_a0, out_b0, out_err0); end
        n_cmp++; if ({out_a1, out_b1} !== {16'h8888, 16'h8888}) begin n_bad++; $display("FAIL min64_ilv got=%h/%h want=8888/8888", out_a1, out_b1); end
        accept_out();
        send(16'h0038);
        wait_out(lat);
        n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL lat56 got=%0d want=9", lat); end
        n_cmp++; if ({out_a0, out_b0, out_err0} !== {16'h7777, 16'h7777, 1'b0}) begin n_bad++; $display("FAIL max56 got=%h/%h/%b want=7777/7777/0", out_a0, out_b0, out_err0); end
        accept_out();
    endtask

    task automatic test_errors;
        logic [15:0] bad [3] = '{16'h0039, 16'h0100, 16'hFFBF};
        int lat;
        foreach (bad[i]) begin
            send(bad[i]);
            wait_out(lat);
            n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL err_lat[%h] got=%0d want=1", bad[i], lat); end
            n_cmp++; if ({out_a0, out_b0, out_err0} !== {16'h0, 16'h0, 1'b1}) begin n_bad++; $display("FAIL err[%h] got=%h/%h/%b want=0000/0000/1", bad[i], out_a0, out_b0, out_err0); end
            n_cmp++; if (out_err1 !== 1'b1) begin n_bad++; $display("FAIL err_ilv[%h] got=%b want=1", bad[i], out_err1); end
            accept_out();
        end
    endtask

    task automatic test_zero;
        int lat;
        send(16'h0000);
        wait_out(lat);
        n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL lat0 got=%0d want=9", lat); end
        n_cmp++; if ({out_a0, out_b0, out_err0, out_a1, out_b1} !== 65'd0) begin n_bad++; $display("FAIL zero got=%h/%h/%b want=0", out_a0, out_b0, out_err0); end
        accept_out();
    endtask

    task automatic test_sweep;
        int vals [10] = '{-1, 1, 7, 8, -8, -9, 33, -37, 49, -63};
        int lat;
        foreach (vals[i]) begin
            send(16'(vals[i]));
            wait_out(lat);
            n_cmp++; if (out_err0 !== 1'b0) begin n_bad++; $display("FAIL sweep_err[%0d] got=%b want=0", vals[i], out_err0); end
            n_cmp++; if (red_of(out_a0, out_b0) !== vals[i]) begin n_bad++; $display("FAIL sweep_seq[%0d] got=%0d (a=%h b=%h)", vals[i], red_of(out_a0, out_b0), out_a0, out_b0); end
            n_cmp++; if (red_of(out_a1, out_b1) !== vals[i]) begin n_bad++; $display("FAIL sweep_ilv[%0d] got=%0d (a=%h b=%h)", vals[i], red_of(out_a1, out_b1), out_a1, out_b1); end
            accept_out();
        end
    endtask

    task automatic test_backpressure;
        int lat;
        send(16'h0005);
        wait_out(lat);
        in_valid = 1'b1;
        in_sum   = 16'h0001;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++; if ({out_valid0, in_ready0} !== 2'b10) begin n_bad++; $display("FAIL bp_hs[%0d] got=%b%b want=10", c, out_valid0, in_ready0); end
            n_cmp++; if ({out_a0, out_b0, out_err0} !== {16'h0005, 16'h0000, 1'b0}) begin n_bad++; $display("FAIL bp_hold[%0d] got=%h/%h/%b want=0005/0000/0", c, out_a0, out_b0, out_err0); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_cmp++; if ({in_ready0, out_valid0} !== 2'b10) begin n_bad++; $display("FAIL bp_release got=%b%b want=10", in_ready0, out_valid0); end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_split;
        int lat;
        send(16'h0014);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({in_ready0, out_valid0} !== 2'b10) begin n_bad++; $display("FAIL abort_state got=%b%b want=10", in_ready0, out_valid0); end
        n_cmp++; if ({out_a0, out_b0, out_err0, out_a1, out_b1} !== 65'd0) begin n_bad++; $display("FAIL abort_outputs got=%h/%h/%h/%h want=0", out_a0, out_b0, out_a1, out_b1); end
        #3;
        rst_n = 1'b1;
        send(16'hFFFD);
        wait_out(lat);
        n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL post_reset_lat got=%0d want=9", lat); end
        n_cmp++; if ({out_a0, out_b0, out_err0} !== {16'h000D, 16'h0000, 1'b0}) begin n_bad++; $display("FAIL neg3 got=%h/%h/%b want=000D/0000/0", out_a0, out_b0, out_err0); end
        n_cmp++; if ({out_a1, out_b1} !== {16'h000D, 16'h0000}) begin n_bad++; $display("FAIL neg3_ilv got=%h/%h want=000D/0000", out_a1, out_b1); end
        accept_out();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sum    = 16'h0;
        out_ready = 1'b0;
        #12;
        test_reset();
        rst_n = 1'b1;
        #10;
        test_reset();
        test_basic();
        test_extremes();
        test_errors();
        test_zero();
        test_sweep();
        test_backpressure();
        test_reset_mid_split();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/red_expand.md
Name: red_expand

Overview:
- Multi-cycle inverse of the ALU RED reduction.
- Takes a 16-bit sign-extended RED result and produces an operand pair (A, B) whose RED reduction equals that result.
- Emits one signed nibble per cycle, with valid/ready handshakes on both sides.
- Sits beside the ALU in the test/operand-generation path. It supplies operand pairs for RED directed tests and checks that a RED result is in range.

Parameters:
- INTERLEAVE, 0, nibble fill order. 0 = A0,A1,A2,A3,B0,B1,B2,B3. 1 = A0,B0,A1,B1,A2,B2,A3,B3 (Xn = bits [4n+3:4n]).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_sum is valid.
- in_ready  out  1  block can accept; equals (state==IDLE).
- in_sum  in  16  target RED result, two's complement.
- out_valid  out  1  out_a/out_b/out_err are valid; equals (state==DONE).
- out_ready  in  1  consumer accepts the output.
- out_a  out  16  generated operand A.
- out_b  out  16  generated operand B.
- out_err  out  1  target is unreachable or badly formed; out_a = out_b = 0.

Behaviour:
- One clock, asynchronous active-low reset. Reset sets state=IDLE; out_a, out_b, out_err, remaining and idx = 0. So in_ready=1 and out_valid=0 while reset is asserted and after it is released.
- Reset asserted mid-SPLIT or mid-DONE aborts the operation immediately. No output is produced.
- Input check:
  - Valid: in_sum[15:6] all equal (a legal 7-bit sign extension) and -64 <= in_sum <= 56.
  - 56 is the largest reachable value (8 × 7), so 57..63 are errors.
- IDLE:
  - On in_valid & in_ready, clear out_a, out_b and idx.
  - Valid input: latch remaining = in_sum[6:0] (7-bit signed), out_err=0, go to SPLIT.
  - Invalid input: out_err=1, go directly to DONE.
- SPLIT, one nibble per cycle:
  - n = clamp(remaining, -8, +7).
  - Write n[3:0] to the nibble slot selected by idx under the fill order.
  - remaining <= remaining - n (7-bit signed; no overflow is possible for legal input).
  - idx <= idx + 1.
  - After the write for idx==7, go to DONE.
- Greedy clamping guarantees remaining==0 after 8 nibbles for any legal input. Unwritten nibbles stay 0.
- DONE:
  - Hold out_a, out_b and out_err stable while out_valid=1 and out_ready=0.
  - On out_ready, go to IDLE.
  - One bubble cycle follows: no input is accepted in the same cycle as an output handshake.
- Latency, counting the input handshake as cycle 0:
  - Legal input: SPLIT in cycles 1..8, out_valid in cycle 9.
  - Error input: out_valid in cycle 1.
- Invariant for every non-error output: RED(out_a, out_b) == in_sum.
- in_valid while busy is ignored (in_ready=0). in_sum need not be held after its handshake.

Optional Feature:
- Macro: RED_EXPAND_EARLY_EXIT_EN.
- Defined: at the start of any SPLIT cycle where remaining==0, go straight to DONE without writing. The remaining slots are already 0. Zero input reaches out_valid in cycle 2; input 20 reaches it in cycle 4.
- Undefined: SPLIT always runs all 8 cycles; latency is fixed at 9 for legal input.
- Outputs are identical either way; only latency differs.

Decomposition:
- Package red_pkg holds:
  - state encoding: IDLE, SPLIT, DONE;
  - NIB_MIN=-8, NIB_MAX=7;
  - SUM_MIN=-64, SUM_MAX=56;
  - NUM_NIBBLES=8.
- Sub-module nibble_clamp (combinational): 7-bit signed remaining in; 4-bit nibble and 7-bit next-remaining out.
- FSM, idx counter, slot decode and handshakes stay in red_expand.

Test Plan:
- in_sum=0x0014 (20), INTERLEAVE=0, macro off -> out_valid in cycle 9; out_a=0x0677, out_b=0x0000, out_err=0. With INTERLEAVE=1 -> out_a=0x0067, out_b=0x0007.
- in_sum=0xFFC0 (-64) -> out_a=0x8888, out_b=0x8888, out_err=0. in_sum=0x0038 (56) -> out_a=0x7777, out_b=0x7777.
- in_sum=0x0039 (57) and in_sum=0x0100 (bad sign extension) -> out_valid in cycle 1; out_err=1, out_a=out_b=0.
- in_sum=0x0000 -> zeros with out_valid in cycle 9 (macro off) or cycle 2 (macro on); random legal sweep checks RED(out_a,out_b)==in_sum.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, with in_valid=1 throughout -> outputs stable, in_ready=0, nothing accepted; in_ready returns 1 in the cycle after the out handshake.
- Assert rst_n=0 asynchronously during SPLIT (idx=3) -> outputs and state cleared without a clock; after release, a new request of 0xFFFD (-3) gives out_a=0x000D, out_b=0.
